// File: rtl/vrf_pkg.sv
// Shared types and constants for the banked vector register file.
package vrf_pkg;

    localparam int unsigned DEF_NUM_REGS = 4;
    localparam int unsigned DEF_LANES    = 4;
    localparam int unsigned DEF_LANE_W   = 8;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_CLEAR,
        CLR_DONE
    } clr_state_t;

    // Low bit index of a lane inside a packed vector word.
    function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned lane_w);
        return lane * lane_w;
    endfunction

endpackage

// File: rtl/vrf_clear_fsm.sv
// Sequential bulk-clear engine: zeroes one register per cycle, then pulses done.
module vrf_clear_fsm
    import vrf_pkg::*;
#(
    parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_clr_req,
    output logic              o_clr_busy,
    output logic              o_clr_done,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    clr_state_t        r_state;
    clr_state_t        w_state_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_next;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= CLR_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        o_clr_busy   = 1'b0;
        o_clr_done   = 1'b0;
        o_clr_we     = 1'b0;
        case (r_state)
            CLR_IDLE: begin
                if (i_clr_req) begin
                    w_state_next = CLR_CLEAR;
                    w_ptr_next   = '0;
                end
            end
            CLR_CLEAR: begin
                o_clr_busy = 1'b1;
                o_clr_we   = 1'b1;
                // Pointer wraps back to 0 as the last register is cleared.
                w_ptr_next = r_ptr + 1'b1;
                if (r_ptr == ADDR_W'(NUM_REGS - 1))
                    w_state_next = CLR_DONE;
            end
            CLR_DONE: begin
                o_clr_done   = 1'b1;
                w_state_next = CLR_IDLE;
            end
            default: w_state_next = CLR_IDLE;
        endcase
    end

    assign o_clr_addr = r_ptr;

endmodule

// File: rtl/vrf_banked.sv
// Vector register file: two async read ports, masked sync write, bulk-clear engine.
// Optional write-through read bypass enabled by defining VRF_BYPASS_EN.
module vrf_banked
    import vrf_pkg::*;
#(
    parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter  int unsigned LANES    = DEF_LANES,
    parameter  int unsigned LANE_W   = DEF_LANE_W,
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS),
    localparam int unsigned VEC_W    = LANES * LANE_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         vreg1,
    input  logic [ADDR_W-1:0]         vreg2,
    output logic [VEC_W-1:0]          vdata1,
    output logic [VEC_W-1:0]          vdata2,
    input  logic                      VRFWrite,
    input  logic [ADDR_W-1:0]         vregw,
    input  logic [LANES-1:0]          vlane_mask,
    input  logic [VEC_W-1:0]          vdataw,
    output logic                      wr_ready,
    input  logic                      clr_req,
    output logic                      clr_busy,
    output logic                      clr_done,
    output logic [NUM_REGS*VEC_W-1:0] vregs_flat
);

    logic [VEC_W-1:0]  r_regs [NUM_REGS];
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_wr_en;
    logic [VEC_W-1:0]  w_rd1;
    logic [VEC_W-1:0]  w_rd2;

    vrf_clear_fsm #(
        .NUM_REGS (NUM_REGS)
    ) u_clear_fsm (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_clr_req  (clr_req),
        .o_clr_busy (clr_busy),
        .o_clr_done (clr_done),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    assign wr_ready = ~clr_busy;
    assign w_wr_en  = VRFWrite & wr_ready;

    // Clear and user write never coincide: wr_ready is low whenever the engine writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_REGS; k++)
                r_regs[k] <= '0;
        end else if (w_clr_we) begin
            r_regs[w_clr_addr] <= '0;
        end else if (w_wr_en) begin
            for (int unsigned i = 0; i < LANES; i++)
                if (vlane_mask[i])
                    r_regs[vregw][lane_lo(i, LANE_W) +: LANE_W] <= vdataw[lane_lo(i, LANE_W) +: LANE_W];
        end
    end

    always_comb begin
        w_rd1 = r_regs[vreg1];
        w_rd2 = r_regs[vreg2];
`ifdef VRF_BYPASS_EN
        if (w_wr_en) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (vlane_mask[i] && (vreg1 == vregw))
                    w_rd1[lane_lo(i, LANE_W) +: LANE_W] = vdataw[lane_lo(i, LANE_W) +: LANE_W];
                if (vlane_mask[i] && (vreg2 == vregw))
                    w_rd2[lane_lo(i, LANE_W) +: LANE_W] = vdataw[lane_lo(i, LANE_W) +: LANE_W];
            end
        end
`endif
    end

    assign vdata1 = w_rd1;
    assign vdata2 = w_rd2;

    always_comb begin
        vregs_flat = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++)
            vregs_flat[k*VEC_W +: VEC_W] = r_regs[k];
    end

endmodule

// File: tb/tb_vrf_banked.sv
// Directed self-checking bench for vrf_banked (NUM_REGS=4, LANES=4, LANE_W=8).
module tb_vrf_banked;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   vreg1 = '0;
    logic [1:0]   vreg2 = '0;
    logic [31:0]  vdata1;
    logic [31:0]  vdata2;
    logic         VRFWrite = 1'b0;
    logic [1:0]   vregw = '0;
    logic [3:0]   vlane_mask = '0;
    logic [31:0]  vdataw = '0;
    logic         wr_ready;
    logic         clr_req = 1'b0;
    logic         clr_busy;
    logic         clr_done;
    logic [127:0] vregs_flat;

    int checks = 0;
    int errors = 0;

    vrf_banked #(
        .NUM_REGS (4),
        .LANES    (4),
        .LANE_W   (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .vreg1      (vreg1),
        .vreg2      (vreg2),
        .vdata1     (vdata1),
        .vdata2     (vdata2),
        .VRFWrite   (VRFWrite),
        .vregw      (vregw),
        .vlane_mask (vlane_mask),
        .vdataw     (vdataw),
        .wr_ready   (wr_ready),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .vregs_flat (vregs_flat)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
        VRFWrite   = 1'b1;
        vregw      = a;
        vdataw     = d;
        vlane_mask = m;
        tick();
        VRFWrite   = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_flat", vregs_flat, '0);
        reset = 1'b0;
        #1;
        chk("rst_busy", clr_busy, 1'b0);
        chk("rst_done", clr_done, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b1);

        // Masked writes
        wr(2'd2, 32'hAABBCCDD, 4'b1111);
        wr(2'd2, 32'h11223344, 4'b0101);
        vreg1 = 2'd2;
        #1;
        chk("mask_merge", vdata1, 32'hAA22CC44);
        wr(2'd2, 32'h55555555, 4'b0000);
        chk("mask_zero", vdata1, 32'hAA22CC44);

        // Dual simultaneous reads
        wr(2'd1, 32'h01010101, 4'b1111);
        wr(2'd3, 32'h03030303, 4'b1111);
        vreg1 = 2'd1;
        vreg2 = 2'd3;
        #1;
        chk("dual_rd1", vdata1, 32'h01010101);
        chk("dual_rd2", vdata2, 32'h03030303);
        chk("flat_after_wr", vregs_flat, {32'h03030303, 32'hAA22CC44, 32'h01010101, 32'h00000000});

        // Bulk clear with a dropped write
        for (int k = 0; k < 4; k++) wr(2'(k), 32'hFFFFFFFF, 4'b1111);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("clr_busy_c1", clr_busy, 1'b1);
        chk("clr_ready_c1", wr_ready, 1'b0);
        chk("clr_flat_c1", vregs_flat, {4{32'hFFFFFFFF}});
        tick();
        chk("clr_flat_c2", vregs_flat, {{3{32'hFFFFFFFF}}, 32'h0});
        VRFWrite   = 1'b1;
        vregw      = 2'd0;
        vdataw     = 32'h12345678;
        vlane_mask = 4'b1111;
        tick();
        chk("clr_flat_c3", vregs_flat, {{2{32'hFFFFFFFF}}, 64'h0});
        chk("clr_busy_c3", clr_busy, 1'b1);
        tick();
        chk("clr_flat_c4", vregs_flat, {32'hFFFFFFFF, 96'h0});
        chk("clr_done_c4", clr_done, 1'b0);
        tick();
        VRFWrite = 1'b0;
        chk("clr_done_c5", clr_done, 1'b1);
        chk("clr_busy_c5", clr_busy, 1'b0);
        chk("clr_flat_c5", vregs_flat, '0);
        tick();
        chk("clr_done_c6", clr_done, 1'b0);
        chk("clr_drop_wr", vregs_flat, '0);

        // Reset mid-clear, clr_req during clear ignored
        for (int k = 0; k < 4; k++) wr(2'(k), 32'hFFFFFFFF, 4'b1111);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        clr_req = 1'b1;
        tick();
        chk("midclr_busy", clr_busy, 1'b1);
        chk("midclr_flat", vregs_flat, {{2{32'hFFFFFFFF}}, 64'h0});
        reset = 1'b1;
        #1;
        chk("async_rst_flat", vregs_flat, '0);
        chk("async_rst_busy", clr_busy, 1'b0);
        chk("async_rst_done", clr_done, 1'b0);
        chk("async_rst_ready", wr_ready, 1'b1);
        tick();
        clr_req = 1'b0;
        reset   = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_no_done", {clr_done, clr_busy}, 2'b00);
        end

        // Write-through bypass
        vreg1      = 2'd1;
        vreg2      = 2'd1;
        VRFWrite   = 1'b1;
        vregw      = 2'd1;
        vdataw     = 32'hDEADBEEF;
        vlane_mask = 4'b0011;
        #1;
`ifdef VRF_BYPASS_EN
        chk("bypass_same_cycle1", vdata1, 32'h0000BEEF);
        chk("bypass_same_cycle2", vdata2, 32'h0000BEEF);
`else
        chk("bypass_same_cycle1", vdata1, 32'h00000000);
        chk("bypass_same_cycle2", vdata2, 32'h00000000);
`endif
        tick();
        VRFWrite = 1'b0;
        #1;
        chk("bypass_next_cycle", vdata1, 32'h0000BEEF);
        chk("bypass_flat", vregs_flat, {64'h0, 32'h0000BEEF, 32'h0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
